game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Per-frame game controller that sequences jumplogic and the scroll datapath. Syncs frame_clk (VGA_VS) into the Clk domain and on each frame issues a physics step, then a conditional world scroll. Owns game state (attract/play/over), score and game_reset. Sits between keycode/VGA timing and jumplogic/platform logic in doodlejump.

Parameters:
SCROLL_LINE, 10'd160, BallY threshold; ball above it triggers a scroll
BOTTOM_Y, 10'd479, BallY at or below which the game ends
START_KEY, 8'h2C, keycode that starts a game (space)
TIMEOUT, 16'd50000, max Clk cycles to wait for phys_done/scroll_done

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  VGA_VS, asynchronous to Clk
keycode  in  8  current USB keycode
BallY  in  10  ball Y from jumplogic, valid when phys_done=1
phys_done  in  1  one-cycle pulse: physics step complete
scroll_done  in  1  one-cycle pulse: scroll applied
phys_go  out  1  one-cycle pulse: run one physics step
scroll_go  out  1  one-cycle pulse: apply scroll_amt
scroll_amt  out  10  scroll distance, stable from scroll_go until scroll_done
game_reset  out  1  one-cycle pulse: reinitialise ball/platforms
state  out  3  current FSM state encoding
score  out  16  accumulated scroll distance, saturating
missed  out  8  frames dropped while busy, saturating
err  out  1  sticky: handshake timeout occurred

Behaviour:
- Reset (async) value of every output is 0; FSM enters ATTRACT; synchronizer flops, key history, counters cleared.
- frame_clk: 3-flop chain s1,s2,s3; frame_tick = s2 & ~s3. phys_go is registered high on the 3rd Clk edge counting the edge that first samples frame_clk=1.
- start_edge = (keycode==START_KEY) & (prev_keycode!=START_KEY); prev_keycode registered each cycle.
- States (encoding): ATTRACT=0, WAIT_FRAME=1, PHYS=2, SCROLL=3, OVER=4.
- ATTRACT: on start_edge -> pulse game_reset, score<=0, missed<=0, go WAIT_FRAME. frame_tick ignored.
- WAIT_FRAME: on frame_tick -> pulse phys_go, clear timer, go PHYS.
- PHYS: wait phys_done. On phys_done, priority: (1) BallY>=BOTTOM_Y -> OVER; (2) BallY<SCROLL_LINE -> scroll_amt<=SCROLL_LINE-BallY (10-bit, no underflow possible), pulse scroll_go next cycle, go SCROLL; (3) else WAIT_FRAME.
- SCROLL: wait scroll_done -> score<=min(score+scroll_amt,16'hFFFF) (17-bit sum, saturate), go WAIT_FRAME. scroll_amt held until scroll_done.
- OVER: score frozen; start_edge -> same as ATTRACT start (game_reset pulse, clears, WAIT_FRAME).
- Timeout: timer counts in PHYS/SCROLL; reaching TIMEOUT -> err<=1 (sticky until Reset), go WAIT_FRAME, no score update.
- frame_tick while in PHYS or SCROLL: missed<=missed+1 saturating at 8'hFF; frame not queued.
- Simultaneous frame_tick and phys_done/scroll_done in same cycle: counts as missed; done processed normally.
- start_edge in WAIT_FRAME/PHYS/SCROLL ignored.
- phys_done/scroll_done outside the waiting state ignored.
- Reset mid-handshake: immediate ATTRACT, all pulses deasserted asynchronously.
- phys_go, scroll_go, game_reset never high more than one cycle, never together.

Optional Feature:
PAUSE_EN: when defined, adds state PAUSE=5 and parameter PAUSE_KEY=8'h13 ('P'). Rising edge of PAUSE_KEY in WAIT_FRAME -> PAUSE; in PAUSE another edge -> WAIT_FRAME; frame_tick in PAUSE ignored and not counted in missed. Rising edge in PHYS/SCROLL deferred: latched, and the transition to PAUSE is taken instead of WAIT_FRAME on completion. Without macro: PAUSE_KEY has no effect, state never 5.

Test Plan:
- Reset asserted mid-PHYS -> all outputs 0, state=0 immediately; after release, frame_clk toggling gives no phys_go.
- keycode 0x00->0x2C -> one game_reset pulse, state=1; hold 0x2C 100 cycles -> no second pulse.
- frame_clk rise, phys_done with BallY=100 -> scroll_go with scroll_amt=60; scroll_done -> score=60, state=1.
- Score at 16'hFFF0, scroll_amt=60 -> score=16'hFFFF.
- phys_done with BallY=479 -> state=4; later frames produce no phys_go; new 0x2C edge -> game_reset, score=0.
- Withhold phys_done for TIMEOUT cycles, 2 frame_clk rises meanwhile -> err=1, missed=2, state=1.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Bundle between game_sequencer, the VGA/keyboard front end and the jumplogic/scroll datapath.
interface game_sequencer_if;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [9:0]  BallY;
  logic        phys_done;
  logic        scroll_done;
  logic        phys_go;
  logic        scroll_go;
  logic [9:0]  scroll_amt;
  logic        game_reset;
  logic [2:0]  state;
  logic [15:0] score;
  logic [7:0]  missed;
  logic        err;

  modport master (
    input  frame_clk, keycode, BallY, phys_done, scroll_done,
    output phys_go, scroll_go, scroll_amt, game_reset, state, score, missed, err
  );

  modport slave (
    output frame_clk, keycode, BallY, phys_done, scroll_done,
    input  phys_go, scroll_go, scroll_amt, game_reset, state, score, missed, err
  );
endinterface

// File: rtl/game_sequencer.sv
// Per-frame game controller: syncs VGA_VS, runs physics then conditional scroll, tracks score.
// Optional PAUSE_EN adds a PAUSE state toggled by rising edges of PAUSE_KEY.
module game_sequencer #(
  parameter logic [9:0]  SCROLL_LINE = 10'd160,
  parameter logic [9:0]  BOTTOM_Y    = 10'd479,
  parameter logic [7:0]  START_KEY   = 8'h2C,
  parameter logic [15:0] TIMEOUT     = 16'd50000
`ifdef PAUSE_EN
  , parameter logic [7:0] PAUSE_KEY  = 8'h13
`endif
) (
  input logic              Clk,
  input logic              Reset,
  game_sequencer_if.master bus
);

  localparam logic [2:0] ST_ATTRACT = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_PHYS    = 3'd2;
  localparam logic [2:0] ST_SCROLL  = 3'd3;
  localparam logic [2:0] ST_OVER    = 3'd4;
`ifdef PAUSE_EN
  localparam logic [2:0] ST_PAUSE   = 3'd5;
`endif

  logic [2:0]  sync_q;
  logic [7:0]  prev_key_q;
  logic [2:0]  state_q, state_d;
  logic        phys_go_q, phys_go_d;
  logic        scroll_go_q, scroll_go_d;
  logic        game_reset_q, game_reset_d;
  logic [9:0]  scroll_amt_q, scroll_amt_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  missed_q, missed_d;
  logic        err_q, err_d;
  logic [15:0] timer_q, timer_d;

  logic        frame_tick_c, start_edge_c, busy_c, to_hit_c;
  logic [2:0]  resume_c;
  logic [16:0] sum_c;

  assign frame_tick_c = sync_q[1] & ~sync_q[2];
  assign start_edge_c = (bus.keycode == START_KEY) && (prev_key_q != START_KEY);
  assign busy_c       = (state_q == ST_PHYS) || (state_q == ST_SCROLL);
  assign to_hit_c     = (timer_q == TIMEOUT - 16'd1);
  assign sum_c        = {1'b0, score_q} + {7'd0, scroll_amt_q};

`ifdef PAUSE_EN
  logic pause_edge_c, pend_q, pend_d;
  assign pause_edge_c = (bus.keycode == PAUSE_KEY) && (prev_key_q != PAUSE_KEY);
  // A pause requested mid-handshake is honoured once the handshake completes.
  assign resume_c     = (pend_q | pause_edge_c) ? ST_PAUSE : ST_WAIT;
`else
  assign resume_c     = ST_WAIT;
`endif

  always_comb begin
    state_d      = state_q;
    phys_go_d    = 1'b0;
    scroll_go_d  = 1'b0;
    game_reset_d = 1'b0;
    scroll_amt_d = scroll_amt_q;
    score_d      = score_q;
    missed_d     = missed_q;
    err_d        = err_q;
    timer_d      = timer_q;
`ifdef PAUSE_EN
    pend_d       = pend_q | (busy_c & pause_edge_c);
`endif

    if (busy_c && frame_tick_c && (missed_q != 8'hFF))
      missed_d = missed_q + 8'd1;

    case (state_q)
      ST_ATTRACT, ST_OVER: begin
        if (start_edge_c) begin
          game_reset_d = 1'b1;
          score_d      = 16'd0;
          missed_d     = 8'd0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
`ifdef PAUSE_EN
        if (pause_edge_c) state_d = ST_PAUSE;
        else
`endif
        if (frame_tick_c) begin
          phys_go_d = 1'b1;
          timer_d   = 16'd0;
          state_d   = ST_PHYS;
        end
      end
      ST_PHYS: begin
        if (bus.phys_done) begin
          if (bus.BallY >= BOTTOM_Y) begin
            state_d = ST_OVER;
          end else if (bus.BallY < SCROLL_LINE) begin
            scroll_amt_d = SCROLL_LINE - bus.BallY;
            scroll_go_d  = 1'b1;
            timer_d      = 16'd0;
            state_d      = ST_SCROLL;
          end else begin
            state_d = resume_c;
          end
        end else if (to_hit_c) begin
          err_d   = 1'b1;
          state_d = resume_c;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_SCROLL: begin
        if (bus.scroll_done) begin
          score_d = sum_c[16] ? 16'hFFFF : sum_c[15:0];
          state_d = resume_c;
        end else if (to_hit_c) begin
          err_d   = 1'b1;
          state_d = resume_c;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
`ifdef PAUSE_EN
      ST_PAUSE: begin
        if (pause_edge_c) state_d = ST_WAIT;
      end
`endif
      default: state_d = ST_ATTRACT;
    endcase

`ifdef PAUSE_EN
    if ((state_d != ST_PHYS) && (state_d != ST_SCROLL)) pend_d = 1'b0;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q       <= 3'd0;
      prev_key_q   <= 8'd0;
      state_q      <= ST_ATTRACT;
      phys_go_q    <= 1'b0;
      scroll_go_q  <= 1'b0;
      game_reset_q <= 1'b0;
      scroll_amt_q <= 10'd0;
      score_q      <= 16'd0;
      missed_q     <= 8'd0;
      err_q        <= 1'b0;
      timer_q      <= 16'd0;
`ifdef PAUSE_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[1:0], bus.frame_clk};
      prev_key_q   <= bus.keycode;
      state_q      <= state_d;
      phys_go_q    <= phys_go_d;
      scroll_go_q  <= scroll_go_d;
      game_reset_q <= game_reset_d;
      scroll_amt_q <= scroll_amt_d;
      score_q      <= score_d;
      missed_q     <= missed_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
`ifdef PAUSE_EN
      pend_q       <= pend_d;
`endif
    end
  end

  assign bus.phys_go    = phys_go_q;
  assign bus.scroll_go  = scroll_go_q;
  assign bus.game_reset = game_reset_q;
  assign bus.scroll_amt = scroll_amt_q;
  assign bus.state      = state_q;
  assign bus.score      = score_q;
  assign bus.missed     = missed_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus randomized play against a reference model.
module tb_game_sequencer;

  localparam int TO = 40;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 0;
  int   p_cnt = -1, s_cnt = -1, f_cnt = 0;

  game_sequencer_if bus ();

  game_sequencer #(.TIMEOUT(16'(TO))) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step of the game rules per clock.
  typedef struct packed {
    int st; int score; int missed; int amt; int waited;
    bit err; bit pg; bit sg; bit gr;
    bit [2:0] fc;
    logic [7:0] prev;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c, input bit fclk, input logic [7:0] key,
                                        input logic [9:0] y, input bit pd, input bit sd);
    model_t n = c;
    bit tick  = c.fc[1] && !c.fc[2];
    bit start = (key == 8'h2C) && (c.prev != 8'h2C);
    bit busy  = (c.st == 2) || (c.st == 3);
    n.fc = {c.fc[1:0], fclk};
    n.prev = key;
    n.pg = 0; n.sg = 0; n.gr = 0;
    if (busy && tick) n.missed = (c.missed >= 255) ? 255 : c.missed + 1;
    if ((c.st == 0 || c.st == 4) && start) begin
      n.gr = 1; n.score = 0; n.missed = 0; n.st = 1;
    end else if (c.st == 1 && tick) begin
      n.pg = 1; n.waited = 0; n.st = 2;
    end else if (busy) begin
      if (c.st == 2 && pd) begin
        if (int'(y) >= 479) n.st = 4;
        else if (int'(y) < 160) begin
          n.amt = 160 - int'(y); n.sg = 1; n.waited = 0; n.st = 3;
        end else n.st = 1;
      end else if (c.st == 3 && sd) begin
        n.score = (c.score + c.amt > 65535) ? 65535 : c.score + c.amt;
        n.st = 1;
      end else if (c.waited + 1 >= TO) begin
        n.err = 1; n.st = 1;
      end else n.waited = c.waited + 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, bus.frame_clk, bus.keycode, bus.BallY, bus.phys_done, bus.scroll_done);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_state",      int'(bus.state),      m.st);
      chk("m_score",      int'(bus.score),      m.score);
      chk("m_missed",     int'(bus.missed),     m.missed);
      chk("m_err",        int'(bus.err),        int'(m.err));
      chk("m_phys_go",    int'(bus.phys_go),    int'(m.pg));
      chk("m_scroll_go",  int'(bus.scroll_go),  int'(m.sg));
      chk("m_game_reset", int'(bus.game_reset), int'(m.gr));
      chk("m_scroll_amt", int'(bus.scroll_amt), m.amt);
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      0:       return bus.phys_go;
      1:       return bus.scroll_go;
      default: return bus.state == 3'd1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int maxc, input string name);
    int n = 0;
    @(negedge clk);
    while (!sig(sel) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(sig(sel)), 1);
  endtask

  // One complete frame: rise frame_clk, answer physics with y, answer scroll if one is issued.
  task automatic do_frame(input logic [9:0] y);
    @(negedge clk);
    bus.frame_clk = 1'b1;
    wait_for(0, 8, "frame_phys_go");
    bus.frame_clk = 1'b0;
    bus.BallY = y;
    bus.phys_done = 1'b1;
    @(negedge clk);
    bus.phys_done = 1'b0;
    if (y < 10'd160) begin
      bus.scroll_done = 1'b1;
      @(negedge clk);
      bus.scroll_done = 1'b0;
    end
  endtask

  task automatic frames_no_go(input int n, input string name);
    int gos = 0;
    for (int i = 0; i < n; i++) begin
      bus.frame_clk = 1'b1;
      repeat (4) begin @(negedge clk); gos += int'(bus.phys_go); end
      bus.frame_clk = 1'b0;
      repeat (4) begin @(negedge clk); gos += int'(bus.phys_go); end
    end
    chk(name, gos, 0);
  endtask

  task automatic rand_cycle();
    int r;
    @(negedge clk);
    bus.phys_done = 1'b0;
    bus.scroll_done = 1'b0;
    bus.BallY = 10'($urandom_range(0, 1023));
    if (bus.phys_go)   p_cnt = ($urandom_range(0, 19) == 0) ? TO + 20 : int'($urandom_range(0, 8));
    if (bus.scroll_go) s_cnt = ($urandom_range(0, 19) == 0) ? TO + 20 : int'($urandom_range(0, 8));
    if (p_cnt == 0 || $urandom_range(0, 63) == 0) begin
      bus.phys_done = 1'b1;
      r = int'($urandom_range(0, 15));
      if (r < 2)      bus.BallY = 10'($urandom_range(479, 1023));
      else if (r < 8) bus.BallY = 10'($urandom_range(0, 159));
      else            bus.BallY = 10'($urandom_range(160, 478));
    end
    if (s_cnt == 0 || $urandom_range(0, 63) == 0) bus.scroll_done = 1'b1;
    if (p_cnt >= 0) p_cnt--;
    if (s_cnt >= 0) s_cnt--;
    if (f_cnt == 0) begin
      bus.frame_clk = ~bus.frame_clk;
      f_cnt = int'($urandom_range(1, 25));
    end else f_cnt--;
    if ($urandom_range(0, 39) == 0) begin
      case ($urandom_range(0, 2))
        0:       bus.keycode = 8'h00;
        1:       bus.keycode = 8'h2C;
        default: bus.keycode = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode = 8'h00;
    bus.BallY = 10'd0;
    bus.phys_done = 1'b0;
    bus.scroll_done = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_phys_go", int'(bus.phys_go), 0);
    chk("rst_err", int'(bus.err), 0);
    rst = 1'b0;

    // Start key edge: exactly one game_reset pulse even when held.
    @(negedge clk);
    bus.keycode = 8'h2C;
    @(negedge clk);
    chk("start_game_reset", int'(bus.game_reset), 1);
    chk("start_state", int'(bus.state), 1);
    cnt = 0;
    repeat (100) begin @(negedge clk); cnt += int'(bus.game_reset); end
    chk("start_held_no_repulse", cnt, 0);

    // phys_go on the third edge after frame_clk rises; BallY=100 scrolls by 60.
    bus.frame_clk = 1'b1;
    @(negedge clk); chk("edge1_phys_go", int'(bus.phys_go), 0);
    @(negedge clk); chk("edge2_phys_go", int'(bus.phys_go), 0);
    @(negedge clk); chk("edge3_phys_go", int'(bus.phys_go), 1);
    chk("edge3_state", int'(bus.state), 2);
    bus.frame_clk = 1'b0;
    bus.BallY = 10'd100;
    bus.phys_done = 1'b1;
    @(negedge clk);
    bus.phys_done = 1'b0;
    chk("scroll_go", int'(bus.scroll_go), 1);
    chk("scroll_amt_60", int'(bus.scroll_amt), 60);
    chk("scroll_state", int'(bus.state), 3);
    bus.scroll_done = 1'b1;
    @(negedge clk);
    bus.scroll_done = 1'b0;
    chk("score_60", int'(bus.score), 60);
    chk("after_scroll_state", int'(bus.state), 1);

    // Drive score to 0xFFF0 (60 + 409*160 + 20), then +60 saturates.
    for (int i = 0; i < 409; i++) do_frame(10'd0);
    do_frame(10'd140);
    chk("score_fff0", int'(bus.score), 16'hFFF0);
    do_frame(10'd100);
    chk("score_sat", int'(bus.score), 16'hFFFF);

    // Fall to the bottom: game over, frames ignored, restart clears score.
    do_frame(10'd479);
    chk("over_state", int'(bus.state), 4);
    frames_no_go(3, "over_no_phys_go");
    chk("over_score_frozen", int'(bus.score), 16'hFFFF);
    bus.keycode = 8'h00;
    @(negedge clk);
    bus.keycode = 8'h2C;
    @(negedge clk);
    chk("restart_game_reset", int'(bus.game_reset), 1);
    chk("restart_score", int'(bus.score), 0);

    // Withhold phys_done with two frame rises meanwhile: timeout, err, two missed.
    bus.frame_clk = 1'b1;
    wait_for(0, 8, "to_phys_go");
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    bus.frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    bus.frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    bus.frame_clk = 1'b0;
    wait_for(2, TO + 20, "to_return_wait");
    chk("to_err", int'(bus.err), 1);
    chk("to_missed", int'(bus.missed), 2);

    // Async reset in the middle of PHYS.
    bus.frame_clk = 1'b1;
    wait_for(0, 8, "rst_phys_go");
    bus.frame_clk = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", int'(bus.state), 0);
    chk("mid_rst_err", int'(bus.err), 0);
    chk("mid_rst_missed", int'(bus.missed), 0);
    chk("mid_rst_score", int'(bus.score), 0);
    chk("mid_rst_scroll_amt", int'(bus.scroll_amt), 0);
    bus.keycode = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    frames_no_go(3, "post_rst_no_phys_go");
    chk("post_rst_state", int'(bus.state), 0);

    // Randomized play checked every cycle by the model.
    for (int i = 0; i < 6000; i++) rand_cycle();
    bus.phys_done = 1'b0;
    bus.scroll_done = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
